// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle control sequencer for a small MIPS datapath.
// Fetches into an instruction register, decodes it, and steps through
// FETCH/DECODE/EXEC/MEM/WB. A PC write strobe gates every PC update.
// MEM waits on mem_ready and faults to HALT if MEM_TIMEOUT cycles elapse.
// Illegal opcodes also halt. Only Reset leaves HALT.
// Optional feature: define MIPS_CTRL_BNE_EN to accept bne (op 0x05).
// bne uses the beq path with the branch condition inverted.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        PCSrc,
  output logic        JumpPC,
  output logic        PCWrite,
  output logic        Halted,
  output logic [1:0]  Fault,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  // Counter value on the last MEM cycle that is allowed before the timeout.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [31:0]      ir_reg, ir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       fault_reg, fault_next;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_nop, is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j;
  logic       is_legal;
  logic [3:0] alu_dec;
  logic       level_en;

  logic reg_write_c, mem_read_c, mem_write_c, pc_src_c, jump_pc_c, pc_write_c;

  // Instruction decode from the instruction register.
  always_comb begin
    op      = ir_reg[31:26];
    funct   = ir_reg[5:0];
    is_nop  = (ir_reg == 32'd0);
    is_r    = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_addi = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    alu_dec = 4'b0000;
    case (op)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          FN_ADD:  alu_dec = ALU_ADD;
          FN_SUB:  alu_dec = ALU_SUB;
          FN_AND:  alu_dec = ALU_AND;
          FN_OR:   alu_dec = ALU_OR;
          FN_SLT:  alu_dec = ALU_SLT;
          default: is_r = 1'b0;
        endcase
      end
      OP_LW: begin
        is_lw   = 1'b1;
        alu_dec = ALU_ADD;
      end
      OP_SW: begin
        is_sw   = 1'b1;
        alu_dec = ALU_ADD;
      end
      OP_ADDI: begin
        is_addi = 1'b1;
        alu_dec = ALU_ADD;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        alu_dec = ALU_SUB;
      end
`ifdef MIPS_CTRL_BNE_EN
      OP_BNE: begin
        is_bne  = 1'b1;
        alu_dec = ALU_SUB;
      end
`else
      OP_BNE: begin
        is_bne  = 1'b0;
        alu_dec = 4'b0000;
      end
`endif
      OP_J:    is_j = 1'b1;
      default: alu_dec = 4'b0000;
    endcase
    is_legal = is_r | is_lw | is_sw | is_addi | is_beq | is_bne | is_j;
  end

  // State, instruction register, MEM wait counter and fault cause.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg <= S_FETCH;
      ir_reg    <= 32'd0;
      cnt_reg   <= '0;
      fault_reg <= FAULT_NONE;
    end else begin
      state_reg <= state_next;
      ir_reg    <= ir_next;
      cnt_reg   <= cnt_next;
      fault_reg <= fault_next;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next  = state_reg;
    ir_next     = ir_reg;
    cnt_next    = cnt_reg;
    fault_next  = fault_reg;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    pc_src_c    = 1'b0;
    jump_pc_c   = 1'b0;
    pc_write_c  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_next    = Instr;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop) begin
          pc_write_c = 1'b1;
          state_next = S_FETCH;
        end else if (is_j) begin
          pc_write_c = 1'b1;
          jump_pc_c  = 1'b1;
          state_next = S_FETCH;
        end else if (!is_legal) begin
          fault_next = FAULT_ILLEGAL;
          state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_r || is_addi) begin
          state_next = S_WB;
        end else if (is_lw || is_sw) begin
          cnt_next   = '0;
          state_next = S_MEM;
        end else if (is_beq || is_bne) begin
          pc_write_c = 1'b1;
          pc_src_c   = is_bne ? ~Zero : Zero;
          state_next = S_FETCH;
        end else begin
          // Not reachable: DECODE only forwards legal non-jump instructions.
          fault_next = FAULT_ILLEGAL;
          state_next = S_HALT;
        end
      end
      S_MEM: begin
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) begin
          // Ready takes priority over a timeout in the same cycle.
          if (is_sw) begin
            pc_write_c = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (cnt_reg == TO_LAST) begin
          fault_next = FAULT_TIMEOUT;
          state_next = S_HALT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_next  = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Level controls follow the IR from DECODE until the instruction retires.
  always_comb begin
    level_en   = (state_reg != S_FETCH) && (state_reg != S_HALT);
    RegDst     = level_en & is_r;
    ALUSrc     = level_en & (is_lw | is_sw | is_addi);
    ALUControl = level_en ? alu_dec : 4'b0000;
    MemToReg   = level_en & is_lw;
    RegWrite   = reg_write_c;
    MemRead    = mem_read_c;
    MemWrite   = mem_write_c;
    PCSrc      = pc_src_c;
    JumpPC     = jump_pc_c;
    PCWrite    = pc_write_c;
    Halted     = (state_reg == S_HALT);
    Fault      = fault_reg;
    State      = state_reg;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: steps each instruction class
// cycle by cycle and compares the full control output vector against
// hand-computed expectations.
module tb_mips_multicycle_ctrl;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_SUB  = 32'h012A4022;
  localparam logic [31:0] I_AND  = 32'h012A4024;
  localparam logic [31:0] I_OR   = 32'h012A4025;
  localparam logic [31:0] I_SLT  = 32'h012A402A;
  localparam logic [31:0] I_LW   = 32'h8D280004;
  localparam logic [31:0] I_SW   = 32'hAD280000;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_BNE  = 32'h15090002;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h21080005;
  localparam logic [31:0] I_ILL  = 32'hFC000000;
  localparam logic [31:0] I_NOP  = 32'h00000000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg;
  logic        PCSrc, JumpPC, PCWrite, Halted;
  logic [3:0]  ALUControl;
  logic [1:0]  Fault;
  logic [2:0]  State;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .PCSrc(PCSrc),
    .JumpPC(JumpPC), .PCWrite(PCWrite), .Halted(Halted), .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  // Order: State RegDst RegWrite ALUSrc ALUControl MemRead MemWrite MemToReg PCSrc JumpPC PCWrite Halted Fault
  logic [18:0] obs;
  assign obs = {State, RegDst, RegWrite, ALUSrc, ALUControl, MemRead, MemWrite,
                MemToReg, PCSrc, JumpPC, PCWrite, Halted, Fault};

  task automatic chk(input string tag, input int st, input int rd, input int rw,
                     input int as, input int ac, input int mr, input int mw,
                     input int m2r, input int ps, input int jp, input int pw,
                     input int h, input int f);
    logic [18:0] exp;
    exp = {3'(st), 1'(rd), 1'(rw), 1'(as), 4'(ac), 1'(mr), 1'(mw), 1'(m2r),
           1'(ps), 1'(jp), 1'(pw), 1'(h), 2'(f)};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_fetch(input string tag);
    chk(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_halt(input string tag, input int f);
    chk(tag, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, f);
  endtask

  // Drive one cycle's inputs just after the falling edge, then settle.
  task automatic cyc(input logic [31:0] ins, input int z, input int rdy);
    @(negedge CLK);
    Instr     = ins;
    Zero      = (z != 0);
    mem_ready = (rdy != 0);
    #1;
  endtask

  // Reset pulse inside a FETCH cycle; releases before the next rising edge.
  task automatic do_reset(input logic [31:0] ins);
    @(negedge CLK);
    Reset     = 1'b0;
    Instr     = ins;
    Zero      = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
  endtask

  task automatic run_r(input string tag, input logic [31:0] ins, input int ac);
    cyc(ins, 0, 0);
    chk_fetch({tag, "_fetch"});
    cyc(0, 0, 0);
    chk({tag, "_dec"}, 1, 1, 0, 0, ac, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk({tag, "_exec"}, 2, 1, 0, 0, ac, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk({tag, "_wb"}, 4, 1, 1, 0, ac, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    // Reset, then add $8,$9,$10
    do_reset(I_ADD);
    cyc(0, 0, 0);
    chk("add_dec", 1, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("add_exec", 2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("add_wb", 4, 1, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0);

    // lw with three wait cycles; mem_ready outside MEM must be ignored
    cyc(I_LW, 0, 1);
    chk_fetch("lw_fetch");
    cyc(0, 0, 1);
    chk("lw_dec", 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1);
    chk("lw_exec", 2, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0);
      chk("lw_mem_wait", 3, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 1);
    chk("lw_mem_ready", 3, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("lw_wb", 4, 0, 1, 1, 2, 0, 0, 1, 0, 0, 1, 0, 0);

    // beq taken, then not taken
    cyc(I_BEQ, 1, 0);
    chk_fetch("beq1_fetch");
    cyc(0, 1, 0);
    chk("beq1_dec", 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0);
    chk("beq1_exec_z1", 2, 0, 0, 0, 6, 0, 0, 0, 1, 0, 1, 0, 0);
    cyc(I_BEQ, 0, 0);
    chk_fetch("beq0_fetch");
    cyc(0, 0, 0);
    chk("beq0_dec", 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("beq0_exec_z0", 2, 0, 0, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0);

    // j, then nop
    cyc(I_J, 0, 0);
    chk_fetch("j_fetch");
    cyc(0, 0, 0);
    chk("j_dec", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(I_NOP, 0, 0);
    chk_fetch("nop_fetch");
    cyc(0, 0, 0);
    chk("nop_dec", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // addi
    cyc(I_ADDI, 0, 0);
    chk_fetch("addi_fetch");
    cyc(0, 0, 0);
    chk("addi_dec", 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("addi_exec", 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("addi_wb", 4, 0, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0);

    // Remaining R-type ALU codes
    run_r("sub", I_SUB, 6);
    run_r("and", I_AND, 0);
    run_r("or",  I_OR,  1);
    run_r("slt", I_SLT, 7);

    // sw: ready arrives on the final allowed MEM cycle and wins
    cyc(I_SW, 0, 0);
    chk_fetch("swr_fetch");
    cyc(0, 0, 0);
    chk("swr_dec", 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("swr_exec", 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0);
      chk("swr_mem_wait", 3, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 1);
    chk("swr_mem_ready_last", 3, 0, 0, 1, 2, 0, 1, 0, 0, 0, 1, 0, 0);

    // sw timeout: exactly 15 MEM cycles, then HALT with Fault=2
    cyc(I_SW, 0, 0);
    chk_fetch("swt_fetch");
    cyc(0, 0, 0);
    chk("swt_dec", 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("swt_exec", 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0);
      chk("swt_mem_wait", 3, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(I_ADD, 1, 1);
      chk_halt("swt_halt", 2);
    end

    // Illegal opcode halts with Fault=1
    do_reset(I_ILL);
    cyc(0, 0, 0);
    chk("ill_dec", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(I_ADD, 0, 1);
    chk_halt("ill_halt", 1);
    cyc(I_LW, 0, 0);
    chk_halt("ill_halt_hold", 1);

    // Asynchronous reset in the middle of a MEM wait
    do_reset(I_SW);
    cyc(0, 0, 0);
    chk("swa_dec", 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("swa_exec", 2, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("swa_mem", 3, 0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    #1;
    Reset = 1'b0;
    #1;
    chk("swa_async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // bne: legal only with the optional feature
    do_reset(I_BNE);
`ifdef MIPS_CTRL_BNE_EN
    cyc(0, 0, 0);
    chk("bne_dec", 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk("bne_exec_z0", 2, 0, 0, 0, 6, 0, 0, 0, 1, 0, 1, 0, 0);
    cyc(I_BNE, 1, 0);
    chk_fetch("bne_fetch2");
    cyc(0, 1, 0);
    chk("bne_dec2", 1, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0);
    chk("bne_exec_z1", 2, 0, 0, 0, 6, 0, 0, 0, 0, 0, 1, 0, 0);
`else
    cyc(0, 0, 0);
    chk("bne_dec_illegal", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0);
    chk_halt("bne_halt", 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
